// File: rtl/camera_stream_packetizer.sv
// Camera pixel stream to Avalon-ST video packetizer with a small FWFT output FIFO.
// Tags sop/eop from x/y frame counters and absorbs downstream backpressure.
module camera_stream_packetizer #(
  parameter int unsigned IMAGE_WIDTH  = 320,
  parameter int unsigned IMAGE_HEIGHT = 240,
  parameter int unsigned DATA_W       = 12,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] pixel_in,
  input  logic              pixel_valid_in,
  input  logic              frame_start_in,
  input  logic              ready_in,
  output logic              valid_out,
  output logic              startofpacket_out,
  output logic              endofpacket_out,
  output logic [DATA_W-1:0] data_out,
  output logic              overflow_out,
  output logic              short_frame_out
);

  localparam int unsigned XW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int unsigned YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = DATA_W + 2;

  localparam logic [XW-1:0] XMax = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] YMax = YW'(IMAGE_HEIGHT - 1);
  localparam logic [CW-1:0] CntFull = CW'(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d, cur_x;
  logic [YW-1:0]   y_q, y_d, cur_y;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            short_q, short_d;
  logic            accept, pix_sop, pix_eop;
  logic            full, do_push, drop, pop;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [EW-1:0]   head;

  // A frame_start forces the current pixel (if any) to be (0,0).
  assign cur_x   = frame_start_in ? '0 : x_q;
  assign cur_y   = frame_start_in ? '0 : y_q;
  assign pix_sop = (cur_x == '0) && (cur_y == '0);
  assign pix_eop = (cur_x == XMax) && (cur_y == YMax);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    accept  = 1'b0;
    short_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_start_in) begin
          state_d = StActive;
          accept  = pixel_valid_in;
        end
      end
      StActive: begin
        accept = pixel_valid_in;
        if (frame_start_in && ((x_q != '0) || (y_q != '0))) short_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      // Geometry advances even when the pixel is dropped on overflow.
      if (cur_x == XMax) begin
        x_d = '0;
        y_d = (cur_y == YMax) ? '0 : cur_y + YW'(1);
      end else begin
        x_d = cur_x + XW'(1);
        y_d = cur_y;
      end
      if (pix_eop) state_d = StIdle;
    end else if (frame_start_in) begin
      x_d = '0;
      y_d = '0;
    end
  end

  // Full is judged on the pre-pop count, so a simultaneous pop never rescues a push.
  assign full    = (count_q == CntFull);
  assign do_push = accept && !full;
  assign drop    = accept && full;
  assign pop     = (count_q != '0) && ready_in;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q;
    if (frame_start_in) overflow_d = 1'b0;
    if (drop)           overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      short_q    <= short_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= {pix_sop, pix_eop, pixel_in};
  end

  assign head              = mem[rd_ptr_q];
  assign valid_out         = (count_q != '0);
  assign startofpacket_out = valid_out ? head[EW-1] : 1'b0;
  assign endofpacket_out   = valid_out ? head[EW-2] : 1'b0;
  assign data_out          = valid_out ? head[DATA_W-1:0] : '0;
  assign overflow_out      = overflow_q;
  assign short_frame_out   = short_q;

endmodule

// File: tb/tb_camera_stream_packetizer.sv
// Directed bench for camera_stream_packetizer using a 4x2 frame and an 8-entry FIFO.
module tb_camera_stream_packetizer;

  localparam int unsigned W = 4;
  localparam int unsigned H = 2;
  localparam int unsigned DW = 12;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] pixel_in = '0;
  logic          pixel_valid_in = 1'b0;
  logic          frame_start_in = 1'b0;
  logic          ready_in = 1'b0;
  logic          valid_out, startofpacket_out, endofpacket_out, overflow_out, short_frame_out;
  logic [DW-1:0] data_out;

  int tests_run = 0;
  int tests_failed = 0;

  camera_stream_packetizer #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .DATA_W      (DW),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .pixel_in         (pixel_in),
    .pixel_valid_in   (pixel_valid_in),
    .frame_start_in   (frame_start_in),
    .ready_in         (ready_in),
    .valid_out        (valid_out),
    .startofpacket_out(startofpacket_out),
    .endofpacket_out  (endofpacket_out),
    .data_out         (data_out),
    .overflow_out     (overflow_out),
    .short_frame_out  (short_frame_out)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    pixel_valid_in = 1'b0;
    frame_start_in = 1'b0;
    ready_in = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Drive one input cycle at the negedge; the DUT samples at the following posedge.
  task automatic drive(input logic v, input logic fs, input logic [DW-1:0] p);
    @(negedge clk);
    pixel_valid_in = v;
    frame_start_in = fs;
    pixel_in = p;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({valid_out, startofpacket_out, endofpacket_out, data_out, overflow_out, short_frame_out}
        !== {3'b000, 12'h000, 2'b00}) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%b s=%b e=%b d=%h ov=%b sh=%b, want all zero",
               valid_out, startofpacket_out, endofpacket_out, data_out, overflow_out,
               short_frame_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 12'h5A0 + 12'(i));
      @(posedge clk);
      #1;
      tests_run++;
      if (valid_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_no_frame_start[%0d]: valid_out=%b, want 0", i, valid_out);
      end
    end
    drive(1'b0, 1'b0, '0);
  endtask

  task automatic test_frame();
    logic [DW-1:0] p;
    apply_reset();
    ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      p = 12'h100 + 12'(i * 17);
      drive(1'b1, i == 0, p);
      @(posedge clk);
      #1;
      tests_run++;
      if ({valid_out, startofpacket_out, endofpacket_out, data_out} !==
          {1'b1, i == 0, i == 7, p}) begin
        tests_failed++;
        $display("FAIL frame_beat[%0d]: got v=%b s=%b e=%b d=%h, want v=1 s=%b e=%b d=%h", i,
                 valid_out, startofpacket_out, endofpacket_out, data_out, i == 0, i == 7, p);
      end
    end
    drive(1'b0, 1'b0, '0);
    @(posedge clk);
    #1;
    tests_run++;
    if (valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_drained: valid_out=%b, want 0", valid_out);
    end
    // Back in idle, pixels without a frame start must be ignored.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 12'hEEE);
      @(posedge clk);
      #1;
      tests_run++;
      if (valid_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL frame_ends_idle[%0d]: valid_out=%b, want 0", i, valid_out);
      end
    end
    drive(1'b0, 1'b0, '0);
  endtask

  task automatic test_backpressure();
    apply_reset();
    ready_in = 1'b0;
    for (int i = 0; i < 8; i++) drive(1'b1, i == 0, 12'h200 + 12'(i));
    drive(1'b0, 1'b0, '0);
    #1;
    tests_run++;
    if ({valid_out, overflow_out, data_out} !== {1'b1, 1'b0, 12'h200}) begin
      tests_failed++;
      $display("FAIL bp_held: got v=%b ov=%b d=%h, want v=1 ov=0 d=200",
               valid_out, overflow_out, data_out);
    end
    ready_in = 1'b1;
    for (int j = 0; j < 8; j++) begin
      #1;
      tests_run++;
      if ({valid_out, startofpacket_out, endofpacket_out, data_out} !==
          {1'b1, j == 0, j == 7, 12'h200 + 12'(j)}) begin
        tests_failed++;
        $display("FAIL bp_drain[%0d]: got v=%b s=%b e=%b d=%h, want v=1 s=%b e=%b d=%h", j,
                 valid_out, startofpacket_out, endofpacket_out, data_out, j == 0, j == 7,
                 12'h200 + 12'(j));
      end
      @(negedge clk);
    end
    #1;
    tests_run++;
    if (valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_empty: valid_out=%b, want 0", valid_out);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp_d [8];
    logic          exp_s [8];
    apply_reset();
    ready_in = 1'b0;
    // Two pixels of frame A, then a restarted frame B of 8: B6 and B7 are dropped.
    drive(1'b1, 1'b1, 12'hA00);
    drive(1'b1, 1'b0, 12'hA01);
    for (int i = 0; i < 8; i++) drive(1'b1, i == 0, 12'hB00 + 12'(i));
    drive(1'b0, 1'b0, '0);
    #1;
    tests_run++;
    if (overflow_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_set: overflow_out=%b, want 1", overflow_out);
    end
    exp_d[0] = 12'hA00; exp_s[0] = 1'b1;
    exp_d[1] = 12'hA01; exp_s[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_d[i+2] = 12'hB00 + 12'(i);
      exp_s[i+2] = (i == 0);
    end
    ready_in = 1'b1;
    for (int j = 0; j < 8; j++) begin
      #1;
      tests_run++;
      if ({valid_out, startofpacket_out, endofpacket_out, data_out, overflow_out} !==
          {1'b1, exp_s[j], 1'b0, exp_d[j], 1'b1}) begin
        tests_failed++;
        $display("FAIL ovf_drain[%0d]: got v=%b s=%b e=%b d=%h ov=%b, want v=1 s=%b e=0 d=%h ov=1",
                 j, valid_out, startofpacket_out, endofpacket_out, data_out, overflow_out,
                 exp_s[j], exp_d[j]);
      end
      @(negedge clk);
    end
    #1;
    tests_run++;
    if ({valid_out, overflow_out} !== 2'b01) begin
      tests_failed++;
      $display("FAIL ovf_sticky: got v=%b ov=%b, want v=0 ov=1", valid_out, overflow_out);
    end
    drive(1'b0, 1'b1, '0);
    @(posedge clk);
    #1;
    tests_run++;
    if (overflow_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_clear: overflow_out=%b, want 0", overflow_out);
    end
    drive(1'b0, 1'b0, '0);
  endtask

  task automatic test_full_pop();
    logic [DW-1:0] exp_d [7];
    apply_reset();
    ready_in = 1'b0;
    // C0..C3 then restart with D0..D3: 8 entries, still mid-frame.
    for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 12'hC00 + 12'(i));
    for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 12'hD00 + 12'(i));
    @(negedge clk);
    ready_in = 1'b1;
    pixel_valid_in = 1'b1;
    frame_start_in = 1'b0;
    pixel_in = 12'hF0F;
    @(posedge clk);
    #1;
    tests_run++;
    if ({valid_out, data_out, overflow_out} !== {1'b1, 12'hC01, 1'b1}) begin
      tests_failed++;
      $display("FAIL full_pop: got v=%b d=%h ov=%b, want v=1 d=c01 ov=1",
               valid_out, data_out, overflow_out);
    end
    drive(1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) exp_d[i] = 12'hC01 + 12'(i);
    for (int i = 0; i < 4; i++) exp_d[i+3] = 12'hD00 + 12'(i);
    for (int j = 0; j < 7; j++) begin
      #1;
      tests_run++;
      if ({valid_out, data_out} !== {1'b1, exp_d[j]}) begin
        tests_failed++;
        $display("FAIL full_drain[%0d]: got v=%b d=%h, want v=1 d=%h", j, valid_out, data_out,
                 exp_d[j]);
      end
      @(negedge clk);
    end
    #1;
    tests_run++;
    if (valid_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_count7: valid_out=%b after 7 pops, want 0", valid_out);
    end
  endtask

  task automatic test_short_frame();
    logic [DW-1:0] p;
    apply_reset();
    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p = 12'h300 + 12'(i);
      drive(1'b1, i == 0, p);
      @(posedge clk);
      #1;
      tests_run++;
      if ({valid_out, startofpacket_out, endofpacket_out, data_out, short_frame_out} !==
          {1'b1, i == 0, 1'b0, p, 1'b0}) begin
        tests_failed++;
        $display("FAIL short_stale[%0d]: got v=%b s=%b e=%b d=%h sh=%b, want v=1 s=%b e=0 d=%h sh=0",
                 i, valid_out, startofpacket_out, endofpacket_out, data_out, short_frame_out,
                 i == 0, p);
      end
    end
    for (int i = 0; i < 8; i++) begin
      p = 12'h400 + 12'(i);
      drive(1'b1, i == 0, p);
      @(posedge clk);
      #1;
      tests_run++;
      if ({valid_out, startofpacket_out, endofpacket_out, data_out, short_frame_out} !==
          {1'b1, i == 0, i == 7, p, i == 0}) begin
        tests_failed++;
        $display("FAIL short_new[%0d]: got v=%b s=%b e=%b d=%h sh=%b, want v=1 s=%b e=%b d=%h sh=%b",
                 i, valid_out, startofpacket_out, endofpacket_out, data_out, short_frame_out,
                 i == 0, i == 7, p, i == 0);
      end
    end
    drive(1'b0, 1'b0, '0);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    ready_in = 1'b0;
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 12'h600 + 12'(i));
    drive(1'b0, 1'b0, '0);
    #1;
    tests_run++;
    if ({valid_out, data_out} !== {1'b1, 12'h600}) begin
      tests_failed++;
      $display("FAIL rst_pre: got v=%b d=%h, want v=1 d=600", valid_out, data_out);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({valid_out, data_out} !== {1'b0, 12'h000}) begin
      tests_failed++;
      $display("FAIL rst_async: got v=%b d=%h, want v=0 d=000", valid_out, data_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 12'h777);
      @(posedge clk);
      #1;
      tests_run++;
      if ({valid_out, overflow_out} !== 2'b00) begin
        tests_failed++;
        $display("FAIL rst_no_stale[%0d]: got v=%b ov=%b, want v=0 ov=0", i, valid_out,
                 overflow_out);
      end
    end
    drive(1'b0, 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_overflow();
    test_full_pop();
    test_short_frame();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
